// File: rtl/matrix_loader_5x5_pkg.sv
// Shared constants and state encoding for the 5x5 matrix loader and its
// determinant-stage handshake.
package matrix_pkg;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int N_ELEM = DIM * DIM;
  localparam int MAT_W  = N_ELEM * ELEM_W;  // 200-bit matrix bus
  localparam int CNT_W  = 5;                // holds 0..25
  localparam int WD_W   = 10;               // holds TIMEOUT up to 1023

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/matrix_loader_5x5_if.sv
// Matrix bus and level start/done handshake between the loader (master)
// and the determinant stage (slave).
interface matrix_loader_5x5_if;
  import matrix_pkg::*;

  logic [MAT_W-1:0]  matrix;
  logic              det_start;
  logic              det_done;
  logic [ELEM_W-1:0] det_result;
  logic              det_overflow;

  modport master (
    output matrix, det_start,
    input  det_done, det_result, det_overflow
  );

  modport slave (
    input  matrix, det_start,
    output det_done, det_result, det_overflow
  );

endinterface

// File: rtl/matrix_loader_5x5_watchdog.sv
// Loadable down-counter. expire pulses on the enabled cycle in which the
// count would step from 1 to 0, so a load of N gives N enabled cycles.
// A load of 0 never expires.
module matrix_watchdog #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load has priority, otherwise count down while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !load && (cnt_q == W'(1));

endmodule

// File: rtl/matrix_loader_5x5.sv
// Serial element loader for the 5x5 determinant stage: packs row-major
// 8-bit writes into the matrix bus, runs the level start/done handshake,
// and captures the determinant with a watchdog abort.
module matrix_loader_5x5 #(
  parameter int ELEM_W  = 8,
  parameter int DIM     = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [ELEM_W-1:0]    wr_data,
  input  logic                 go,
  matrix_loader_5x5_if.master  det,
  output logic [4:0]           load_count,
  output logic                 load_full,
  output logic                 busy,
  output logic [ELEM_W-1:0]    result,
  output logic                 result_ovf,
  output logic                 result_valid,
  output logic                 timeout,
  output logic                 err
);
  import matrix_pkg::*;

  localparam int N = DIM * DIM;

  state_e            state_q, state_d;
  logic [MAT_W-1:0]  mat_q, mat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic [ELEM_W-1:0] res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              to_q, to_d;
  logic              err_q, err_d;
  logic              wd_load;
  logic              wd_expire;
  logic              full;

  assign full = (cnt_q == CNT_W'(N));

  matrix_watchdog #(.W(WD_W)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wd_load),
    .load_val (WD_W'(TIMEOUT)),
    .en       (state_q == RUN),
    .expire   (wd_expire)
  );

  // Next-state logic for the FSM, element store, result capture and err.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    mat_d   = mat_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    to_d    = to_q;
    err_d   = 1'b0;
    wd_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          // Flush wins over any coincident write or go, silently.
          cnt_d   = '0;
          mat_d   = '0;
          valid_d = 1'b0;
        end else begin
          if (wr_en) begin
            if (!full) begin
              mat_d[int'(cnt_q) * ELEM_W +: ELEM_W] = wr_data;
              cnt_d = cnt_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          // go is judged on the pre-write count, so it cannot ride the 25th write.
          if (go) begin
            if (full) begin
              state_d = RUN;
              start_d = 1'b1;
              valid_d = 1'b0;
              to_d    = 1'b0;
              wd_load = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      RUN: begin
        err_d = wr_en | go;
        if (det.det_done) begin
          res_d   = det.det_result;
          ovf_d   = det.det_overflow;
          valid_d = 1'b1;
          start_d = 1'b0;
          state_d = DRAIN;
        end else if (wd_expire) begin
          to_d    = 1'b1;
          start_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Hold off any new run until the stage has dropped done.
        err_d = wr_en | go;
        if (!det.det_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      // NOTE: the matrix store is reset because downstream sees it directly and must read zero out of reset.
      mat_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      mat_q   <= mat_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  assign det.matrix    = mat_q;
  assign det.det_start = start_q;
  assign load_count    = cnt_q;
  assign load_full     = full;
  assign busy          = (state_q != IDLE);
  assign result        = res_q;
  assign result_ovf    = ovf_q;
  assign result_valid  = valid_q;
  assign timeout       = to_q;
  assign err           = err_q;

endmodule
